// File: rtl/otprom_burner.sv
// otprom_burner: burns requested bits of one OTPROM word with a read-modify-write,
// a timed program pulse, a verify read-back and a bounded number of retries.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module otprom_burner #(
  parameter int PULSE_CYCLES = 4,
  parameter int MAX_RETRY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_req,
  output logic                       prog_ready,
  input  logic [`BUS_WIDTH-1:0]      prog_addr,
  input  logic [`DATA_WIDTH-1:0]     prog_data,
  input  logic                       prog_lock,
  output logic                       prog_done,
  output logic [1:0]                 prog_status,
  output logic                       busy,
  output logic [`BUS_WIDTH-1:0]      ram_raddr,
  output logic                       ram_ren,
  input  logic [`DATA_WIDTH-1:0]     ram_rdata,
  output logic [`BUS_WIDTH-1:0]      ram_waddr,
  output logic [`DATA_WIDTH-1:0]     ram_wdata,
  output logic [`DATA_WIDTH/8-1:0]   ram_wen
);

  localparam int AW  = `BUS_WIDTH;
  localparam int DW  = `DATA_WIDTH;
  localparam int PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int RW  = (MAX_RETRY + 1 > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_VRD, S_VCAP, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [DW-1:0]   r_old;
  logic [PW-1:0]   r_pulse;
  logic [RW-1:0]   r_retry;
  logic [1:0]      r_status;
  logic            w_noop;
  logic            w_verified;

  assign w_noop     = (r_data & ~ram_rdata) == '0;
  assign w_verified = (ram_rdata & r_data) == r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_old    <= '0;
      r_pulse  <= '0;
      r_retry  <= '0;
      r_status <= 2'b00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (prog_req) begin
            r_addr  <= prog_addr;
            r_data  <= prog_data;
            r_retry <= '0;
            if (prog_lock) r_status <= 2'b11;
          end
        end
        S_CAP: begin
          r_old   <= ram_rdata;
          r_pulse <= '0;
          if (w_noop) r_status <= 2'b01;
        end
        S_WR: r_pulse <= r_pulse + 1'b1;
        S_VCAP: begin
          if (w_verified) begin
            r_status <= 2'b00;
          end else if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + 1'b1;
            r_pulse <= '0;
          end else begin
            r_status <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM strobes depend on state alone so a reset drops the write immediately.
  always_comb begin
    w_next      = r_state;
    prog_ready  = 1'b0;
    busy        = 1'b1;
    prog_done   = 1'b0;
    ram_ren     = 1'b0;
    ram_raddr   = '0;
    ram_wen     = '0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        prog_ready = 1'b1;
        busy       = 1'b0;
        if (prog_req) w_next = prog_lock ? S_DONE : S_RD;
      end
      S_RD: begin
        ram_ren   = 1'b1;
        ram_raddr = r_addr;
        w_next    = S_CAP;
      end
      S_CAP: w_next = w_noop ? S_DONE : S_WR;
      S_WR: begin
        ram_wen   = '1;
        ram_waddr = r_addr;
        ram_wdata = r_old | r_data;
        if (r_pulse == PULSE_LAST) w_next = S_VRD;
      end
      S_VRD: begin
        ram_ren   = 1'b1;
        ram_raddr = r_addr;
        w_next    = S_VCAP;
      end
      S_VCAP: begin
        if (w_verified)                w_next = S_DONE;
        else if (r_retry < RETRY_MAX)  w_next = S_WR;
        else                           w_next = S_DONE;
      end
      S_DONE: begin
        prog_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign prog_status = r_status;

endmodule

// File: tb/tb_otprom_burner.sv
// tb_otprom_burner: drives directed and random burn requests against a behavioural
// OTPROM array and checks every busy cycle against a timeline model.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_otprom_burner;

  localparam int AW   = `BUS_WIDTH;
  localparam int DW   = `DATA_WIDTH;
  localparam int WEW  = `DATA_WIDTH / 8;
  localparam int P    = 4;
  localparam int MAXR = 2;
  localparam logic [WEW-1:0] WEN_ALL = '1;

  logic            clk = 1'b0;
  logic            reset;
  logic            prog_req;
  logic            prog_ready;
  logic [AW-1:0]   prog_addr;
  logic [DW-1:0]   prog_data;
  logic            prog_lock;
  logic            prog_done;
  logic [1:0]      prog_status;
  logic            busy;
  logic [AW-1:0]   ram_raddr;
  logic            ram_ren;
  logic [DW-1:0]   ram_rdata;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic [WEW-1:0]  ram_wen;

  otprom_burner #(.PULSE_CYCLES(P), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .prog_req(prog_req), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_lock(prog_lock),
    .prog_done(prog_done), .prog_status(prog_status), .busy(busy),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural array: reads return a word one cycle later; a configurable number
  // of whole pulse groups are dropped to emulate cells that need extra pulses.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int  ignoreLeft = 0;
  bit  groupIgnored = 0;
  bit  prevWen = 0;

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
    if (ram_wen != '0) begin
      if (!prevWen) begin
        if (ignoreLeft > 0) begin
          groupIgnored = 1;
          ignoreLeft--;
        end else begin
          groupIgnored = 0;
        end
      end
      if (!groupIgnored) mem[ram_waddr] = ram_wdata;
    end
    prevWen = (ram_wen != '0);
  end

  // Expected transaction, described as a timeline counted from the accept edge.
  bit            txnActive = 0;
  bit            doneSeen  = 0;
  int            cyc       = 0;
  int            doneCyc   = 0;
  logic [1:0]    doneStatus;
  int            expLat, expGroups;
  bit            expLock;
  logic [1:0]    expStatus;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData, expOld;

  function automatic bit expWenAt(input int c);
    for (int g = 0; g < expGroups; g++) begin
      int base = 3 + g * (P + 2);
      if (c >= base && c < base + P) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit expRenAt(input int c);
    if (expLock) return 1'b0;
    if (c == 1) return 1'b1;
    for (int g = 0; g < expGroups; g++)
      if (c == 3 + g * (P + 2) + P) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (txnActive) begin
      cyc++;
      check("busy", busy, cyc <= expLat);
      check("ready", prog_ready, cyc > expLat);
      check("done", prog_done, cyc == expLat);
      check("ren", ram_ren, expRenAt(cyc));
      check("raddr", ram_raddr, expRenAt(cyc) ? expAddr : '0);
      check("wen", ram_wen, expWenAt(cyc) ? WEN_ALL : '0);
      check("waddr", ram_waddr, expWenAt(cyc) ? expAddr : '0);
      check("wdata", ram_wdata, expWenAt(cyc) ? (expOld | expData) : '0);
      if (prog_done) begin
        doneSeen   = 1;
        doneCyc    = cyc;
        doneStatus = prog_status;
        check("status", prog_status, expStatus);
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input bit lock, input logic [DW-1:0] word, input int ignore,
                               input int litLat, input logic [1:0] litStatus,
                               input logic [DW-1:0] litWord);
    logic [DW-1:0] finalWord;
    int need;
    mem[addr]  = word;
    ignoreLeft = ignore;
    expAddr = addr; expData = data; expOld = word; expLock = lock;
    finalWord = word;
    if (lock) begin
      expGroups = 0; expLat = 1; expStatus = 2'b11;
    end else if ((data & ~word) == '0) begin
      expGroups = 0; expLat = 3; expStatus = 2'b01;
    end else begin
      need = ignore + 1;
      if (need <= MAXR + 1) begin
        expGroups = need; expStatus = 2'b00; finalWord = word | data;
      end else begin
        expGroups = MAXR + 1; expStatus = 2'b10;
      end
      expLat = P + 5 + (expGroups - 1) * (P + 2);
    end
    @(negedge clk);
    check("accept_ready", prog_ready, 1'b1);
    prog_addr = addr; prog_data = data; prog_lock = lock; prog_req = 1'b1;
    @(posedge clk);
    #1;
    prog_req = 1'b0;
    prog_lock = 1'b0;
    cyc = 0; doneSeen = 0; txnActive = 1;
    for (int i = 0; i < 200 && !doneSeen; i++) @(posedge clk);
    txnActive = 0;
    check("done_seen", doneSeen, 1'b1);
    #1;
    check("final_word", mem[addr], finalWord);
    if (litLat >= 0) checkOutput(litLat, litStatus, addr, litWord);
  endtask

  task automatic checkOutput(input int litLat, input logic [1:0] litStatus,
                             input logic [AW-1:0] addr, input logic [DW-1:0] litWord);
    check("lit_latency", doneCyc, litLat);
    check("lit_status", doneStatus, litStatus);
    check("lit_word", mem[addr], litWord);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_rdata = '0;
    reset = 1'b1; prog_req = 1'b0; prog_addr = '0; prog_data = '0; prog_lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", prog_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", prog_done, 1'b0);
    check("rst_status", prog_status, 2'b00);
    check("rst_ren", ram_ren, 1'b0);
    check("rst_wen", ram_wen, '0);
    reset = 1'b0;

    applyStimulus(8'h10, 16'h0001, 0, 16'h0000, 0,    9,  2'b00, 16'h0001);
    applyStimulus(8'h10, 16'h0001, 0, 16'h0003, 0,    3,  2'b01, 16'h0003);
    applyStimulus(8'h20, 16'h00FF, 1, 16'h0000, 0,    1,  2'b11, 16'h0000);
    applyStimulus(8'h40, 16'h0080, 0, 16'h0000, 1,    15, 2'b00, 16'h0080);
    applyStimulus(8'h41, 16'h0080, 0, 16'h0000, 1000, 21, 2'b10, 16'h0000);
    applyStimulus(8'h50, 16'h00F0, 0, 16'h000F, 0,    9,  2'b00, 16'h00FF);
    applyStimulus(8'h51, 16'h0000, 0, 16'h1234, 0,    3,  2'b01, 16'h1234);

    // Abort a burn in its second write cycle with an asynchronous reset.
    mem[8'h30] = '0;
    ignoreLeft = 0;
    @(negedge clk);
    prog_addr = 8'h30; prog_data = 16'h0001; prog_lock = 1'b0; prog_req = 1'b1;
    @(posedge clk);
    #1 prog_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_wen", ram_wen, WEN_ALL);
    reset = 1'b1;
    #1;
    check("abort_wen", ram_wen, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", prog_ready, 1'b1);
    check("abort_done", prog_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_abort_done", prog_done, 1'b0);
      check("post_abort_busy", busy, 1'b0);
    end
    applyStimulus(8'h31, 16'h0101, 0, 16'h0010, 0, 9, 2'b00, 16'h0111);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d, w;
      bit lk;
      a  = AW'($urandom_range(0, 15));
      w  = DW'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & w;
      lk = ($urandom_range(0, 5) == 0);
      applyStimulus(a, d, lk, w, $urandom_range(0, 3), -1, 2'b00, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otprom_burner.md
Name: otprom_burner

Overview:
- Write-side controller for the one-time-programmable ROM array. Burns requested bits (0 -> 1) in a single word using a read-modify-write, a timed program pulse, a verify read-back and bounded retries.
- Sits between a programming master (debug/fuse-programming port) and the OTPROM RAM write/read port.
- It is the counterpart of the boot-time fuse reader/agent that latches secure_debug_disable.
- Honors a hardware lock input so programming is refused once the lock fuse is set.

Parameters:
- PULSE_CYCLES, 4: number of consecutive cycles the write is held per program pulse (>=1).
- MAX_RETRY, 2: extra program pulses allowed after a failed verify (>=0).
- Address and data widths come from `BUS_WIDTH and `DATA_WIDTH in defines.vh.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_req  in  1  programming request.
- prog_ready  out  1  high only in IDLE; a request is accepted on prog_req & prog_ready.
- prog_addr  in  `BUS_WIDTH  word address to burn; captured at accept.
- prog_data  in  `DATA_WIDTH  bits to burn (1 = burn); captured at accept.
- prog_lock  in  1  programming disabled; sampled at accept.
- prog_done  out  1  one-cycle completion pulse.
- prog_status  out  2  result: 00 burned OK, 01 no-op (bits already set), 10 verify fail, 11 locked; held until the next accept.
- busy  out  1  high in every state except IDLE.
- ram_raddr  out  `BUS_WIDTH  read address.
- ram_ren  out  1  read enable. Read data is valid on ram_rdata one cycle after ram_ren.
- ram_rdata  in  `DATA_WIDTH  read data.
- ram_waddr  out  `BUS_WIDTH  write address.
- ram_wdata  out  `DATA_WIDTH  write data.
- ram_wen  out  `DATA_WIDTH/8  byte write enables.

Behaviour:
- Reset values: state IDLE, prog_ready=1, busy=0, prog_done=0, prog_status=00, ram_ren=0, ram_wen=0, all captured registers and counters 0.
- RAM controls are decoded from state only, so an asynchronous reset mid-burn removes ram_wen immediately. Any pulse in progress is aborted, no done pulse is generated, and the FSM restarts in IDLE.
- IDLE: on accept, capture addr_q and data_q, clear retry_cnt. If prog_lock=1, go to DONE with status 11 and make no RAM access; otherwise go to RD.
- RD: ram_ren=1, ram_raddr=addr_q -> CAP.
- CAP: old_q <= ram_rdata.
  - If (data_q & ~ram_rdata)==0, go to DONE with status 01 and perform no write.
  - Otherwise clear pulse_cnt and go to WR.
- WR: ram_wen=all ones, ram_waddr=addr_q, ram_wdata=old_q|data_q, all stable every cycle. pulse_cnt increments each cycle; when pulse_cnt==PULSE_CYCLES-1, go to VRD.
- VRD: ram_ren=1, ram_raddr=addr_q -> VCAP.
- VCAP:
  - If (ram_rdata & data_q)==data_q, go to DONE with status 00.
  - Else if retry_cnt<MAX_RETRY, increment retry_cnt, clear pulse_cnt, and go to WR.
  - Else go to DONE with status 10.
- DONE: prog_done=1 for exactly one cycle and prog_status is updated, then return to IDLE. prog_status keeps its value until the next accept.
- Outside RD/VRD: ram_ren=0 and ram_raddr=0. Outside WR: ram_wen=0, ram_waddr=0, ram_wdata=0.
- Bits are never cleared: write data is always a superset of old_q.
- Latency, with accept at cycle T:
  - Locked: done at T+1.
  - No-op: done at T+3.
  - First-try burn: done at T+PULSE_CYCLES+5.
  - Each retry adds PULSE_CYCLES+2 cycles.
- prog_req while busy is ignored; it is not queued. A request held high through DONE is accepted in the following IDLE cycle.
- prog_data=0 is legal and always completes as a no-op (status 01).
- retry_cnt and pulse_cnt are sized with $clog2 of (MAX_RETRY+1) and PULSE_CYCLES, minimum 1 bit.

Test Plan:
- Reset, then accept addr=0x10, data=0x1, with the array word=0x0 and a model that sets bits on write -> ram_wen=all ones for 4 cycles with wdata=0x1, one verify read, prog_done at T+9, status 00, word now 0x1.
- Word 0x10 already 0x3, request data=0x1 -> one read, no ram_wen, prog_done at T+3, status 01.
- prog_lock=1 at accept, addr=0x20, data=0xFF -> no ram_ren and no ram_wen, prog_done at T+1, status 11.
- Model ignores the first write only, data=0x80 -> 2 pulse groups (8 wen cycles), status 00 at T+15. With a model that never burns -> 3 pulse groups, status 10 at T+21.
- Word=0x0F, request data=0xF0 -> wdata=0xFF in every WR cycle, old bits preserved.
- Assert reset during the 2nd WR cycle -> ram_wen=0 in the same cycle, busy=0, no prog_done. A new request after reset completes normally.
